// File: rtl/mem_master_pkg.sv
// Shared constants for the data-memory initiator: operation codes,
// FSM state codes and default widths.
package mem_master_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int NREG_DEF   = 8;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LM = 2'b10;
  localparam logic [1:0] OP_SM = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SCAN = 3'd1;
  localparam state_t ST_XFER = 3'd2;
  localparam state_t ST_WB   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Stores move register data out to memory; loads bring it back.
  function automatic logic op_is_store(input logic [1:0] code);
    return (code == OP_SW) || (code == OP_SM);
  endfunction

  // Block operations take their register set from the mask input.
  function automatic logic op_is_block(input logic [1:0] code);
    return (code == OP_LM) || (code == OP_SM);
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// Memory-port bundle between the initiator and the data memory.
// Strobes are active low; the memory acts on them at the negedge.
interface mem_master_if
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_out;

  modport master (
    output mem_addr,
    output mem_in,
    output mem_write,
    output mem_read,
    input  mem_out
  );

  modport slave (
    input  mem_addr,
    input  mem_in,
    input  mem_write,
    input  mem_read,
    output mem_out
  );

endinterface

// File: rtl/lsb_encoder8.sv
// Lowest-set-bit priority encoder over an 8-bit register mask.
module lsb_encoder8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_master.sv
// Initiator side of the 64x16 data-memory port. Sequences LW/SW and
// register-mask LM/SM transfers, one word per SCAN/XFER(/WB) round.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        reg_sel,
  input  logic [NREG-1:0]   reg_mask,
  output logic [2:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  mem_master_if.master      mem,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              is_store;
  logic [NREG-1:0]   mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        enc_idx;
  logic              enc_valid;

  lsb_encoder8 u_enc (
    .mask  (mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // The register file is read at the lowest pending register at all times;
  // only SCAN actually consumes the data.
  assign rf_raddr = enc_idx;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // Transfer sequencer. Strobes default high every cycle so they can only
  // be low for the single XFER cycle that follows a SCAN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      is_store      <= 1'b0;
      mask_q        <= '0;
      addr_q        <= '0;
      mem.mem_addr  <= '0;
      mem.mem_in    <= '0;
      mem.mem_write <= 1'b1;
      mem.mem_read  <= 1'b1;
      rf_we         <= 1'b0;
      rf_waddr      <= 3'd0;
      rf_wdata      <= '0;
    end else begin
      mem.mem_write <= 1'b1;
      mem.mem_read  <= 1'b1;
      rf_we         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_store <= op_is_store(op);
            addr_q   <= base_addr;
            mask_q   <= op_is_block(op) ? reg_mask
                                        : ({{(NREG-1){1'b0}}, 1'b1} << reg_sel);
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!enc_valid) begin
            state <= ST_DONE;
          end else begin
            mem.mem_addr <= addr_q;
            if (is_store) begin
              mem.mem_in    <= rf_rdata;
              mem.mem_write <= 1'b0;
            end else begin
              mem.mem_read  <= 1'b0;
            end
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (is_store) begin
            mask_q[enc_idx] <= 1'b0;
            addr_q          <= addr_q + ADDR_W'(1);
            state           <= ST_SCAN;
          end else begin
            // Read data arrived at the negedge inside XFER; registering it
            // here places the one-cycle write pulse exactly on WB.
            rf_we    <= 1'b1;
            rf_waddr <= enc_idx;
            rf_wdata <= mem.mem_out;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          mask_q[enc_idx] <= 1'b0;
          addr_q          <= addr_q + ADDR_W'(1);
          state           <= ST_SCAN;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: a negedge memory model and register-file model,
// a table of directed operations and randomized operations, all scored
// against a word-level reference of what each operation must do.
module tb_mem_master;
  import mem_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [5:0]  base_addr = 6'd0;
  logic [2:0]  reg_sel = 3'd0;
  logic [7:0]  reg_mask = 8'd0;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;
  logic        done;

  mem_master_if #(.ADDR_W(6), .DATA_W(16)) mem_bus ();

  mem_master #(.ADDR_W(6), .DATA_W(16), .NREG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .base_addr (base_addr),
    .reg_sel   (reg_sel),
    .reg_mask  (reg_mask),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .mem       (mem_bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Environment state (actual) and reference state (expected)
  logic [15:0] mem [64];
  logic [15:0] rf  [8];
  logic [15:0] exp_mem [64];
  logic [15:0] exp_rf  [8];
  logic [31:0] rf_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] exp_rlog[$];
  logic [31:0] exp_wlog[$];
  int rd_cnt = 0, wr_cnt = 0, both_low = 0;
  int rd0 = 0, wr0 = 0, bl0 = 0;
  int exp_lat = 0, exp_rd = 0, exp_wr = 0;
  int checks = 0, errors = 0;

  assign rf_rdata = rf[rf_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock: memory and register file react at the negedge, then the
  // bench resumes 1ns after the following posedge.
  task automatic tick();
    @(negedge clk);
    if (!mem_bus.mem_write && !mem_bus.mem_read) both_low++;
    if (!mem_bus.mem_write) begin
      mem[mem_bus.mem_addr] = mem_bus.mem_in;
      wr_log.push_back({10'd0, mem_bus.mem_addr, mem_bus.mem_in});
      wr_cnt++;
    end
    if (!mem_bus.mem_read) begin
      mem_bus.mem_out = mem[mem_bus.mem_addr];
      rd_cnt++;
    end
    if (rf_we) begin
      rf[rf_waddr] = rf_wdata;
      rf_log.push_back({13'd0, rf_waddr, rf_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: registers in ascending index order map to
  // consecutive memory words starting at base, modulo 64.
  task automatic model_op(input logic [1:0] o, input logic [5:0] b,
                          input logic [2:0] s, input logic [7:0] m);
    logic [7:0] sel;
    logic [5:0] a;
    int words;
    logic st;
    st = (o == OP_SW) || (o == OP_SM);
    sel = (o == OP_LM || o == OP_SM) ? m : (8'd1 << s);
    words = 0;
    exp_rlog.delete();
    exp_wlog.delete();
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        a = b + 6'(words);
        words++;
        if (st) begin
          exp_mem[a] = exp_rf[i];
          exp_wlog.push_back({10'd0, a, exp_rf[i]});
        end else begin
          exp_rf[i] = exp_mem[a];
          exp_rlog.push_back({13'd0, 3'(i), exp_mem[a]});
        end
      end
    end
    exp_lat = 2 + words * (st ? 2 : 3);
    exp_rd  = st ? 0 : words;
    exp_wr  = st ? words : 0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [5:0] b, input logic [2:0] s,
                        input logic [7:0] m, input int poke, output int lat);
    int k;
    rd0 = rd_cnt; wr0 = wr_cnt; bl0 = both_low;
    rf_log.delete();
    wr_log.delete();
    op = o; base_addr = b; reg_sel = s; reg_mask = m; start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 200) begin
      if (k == poke) begin
        start = 1'b1; op = OP_LM; reg_mask = 8'hFF;
      end
      tick();
      start = 1'b0;
      k++;
    end
    lat = done ? k : -1;
    tick();
  endtask

  task automatic verify(input string tag, input int lat);
    int bad;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_reads"}, rd_cnt - rd0, exp_rd);
    check({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    check({tag, "_both_low"}, both_low - bl0, 0);
    check({tag, "_rflog_len"}, rf_log.size(), exp_rlog.size());
    bad = 0;
    for (int i = 0; i < rf_log.size() && i < exp_rlog.size(); i++)
      if (rf_log[i] !== exp_rlog[i]) bad++;
    check({tag, "_rflog"}, bad, 0);
    check({tag, "_wrlog_len"}, wr_log.size(), exp_wlog.size());
    bad = 0;
    for (int i = 0; i < wr_log.size() && i < exp_wlog.size(); i++)
      if (wr_log[i] !== exp_wlog[i]) bad++;
    check({tag, "_wrlog"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
    for (int i = 0; i < 8; i++) if (rf[i] !== exp_rf[i]) bad++;
    check({tag, "_image"}, bad, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [5:0]  b;
    logic [2:0]  s;
    logic [7:0]  m;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] first;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat;
    logic [31:0] act_first;
    logic [1:0] ro;

    tbl[0] = '{OP_SW, 6'h0A, 3'd3, 8'h00, 4,  0, 1, {10'd0, 6'h0A, 16'hBEEF}};
    tbl[1] = '{OP_LW, 6'h10, 3'd5, 8'hFF, 5,  1, 0, {13'd0, 3'd5, 16'h1234}};
    tbl[2] = '{OP_SM, 6'h00, 3'd0, 8'h00, 2,  0, 0, 32'd0};
    tbl[3] = '{OP_LM, 6'h05, 3'd0, 8'h00, 2,  0, 0, 32'd0};
    tbl[4] = '{OP_SM, 6'h00, 3'd0, 8'h81, 6,  0, 2, {10'd0, 6'h00, 16'h0001}};
    tbl[5] = '{OP_LM, 6'h3E, 3'd0, 8'hA5, 14, 4, 0, {13'd0, 3'd0, 16'hA001}};
    tbl[6] = '{OP_SM, 6'h20, 3'd0, 8'hFF, 18, 0, 8, {10'd0, 6'h20, 16'hA001}};

    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'($urandom);
      exp_rf[i] = rf[i];
    end
    mem[6'h10] = 16'h1234; mem[6'h3E] = 16'hA001; mem[6'h3F] = 16'hA002;
    mem[6'h00] = 16'hA003; mem[6'h01] = 16'hA004;
    rf[0] = 16'h0001; rf[3] = 16'hBEEF; rf[7] = 16'h0002;
    for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < 8; i++) exp_rf[i] = rf[i];
    mem_bus.mem_out = 16'd0;

    // Power-on reset
    tick();
    tick();
    check("por_busy", busy, 0);
    check("por_strobes", {mem_bus.mem_write, mem_bus.mem_read}, 2'b11);
    reset = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      model_op(tbl[i].o, tbl[i].b, tbl[i].s, tbl[i].m);
      run_op(tbl[i].o, tbl[i].b, tbl[i].s, tbl[i].m, 0, lat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_nrd", i), rd_cnt - rd0, tbl[i].nrd);
      check($sformatf("tbl%0d_nwr", i), wr_cnt - wr0, tbl[i].nwr);
      act_first = (tbl[i].o == OP_SW || tbl[i].o == OP_SM)
                  ? ((wr_log.size() > 0) ? wr_log[0] : 32'd0)
                  : ((rf_log.size() > 0) ? rf_log[0] : 32'd0);
      check($sformatf("tbl%0d_first", i), act_first, tbl[i].first);
      verify($sformatf("tbl%0d", i), lat);
    end

    // Asynchronous reset mid-clock while idle with non-zero outputs held
    #2;
    reset = 1'b1;
    #1;
    check("rst_mem_write", mem_bus.mem_write, 1);
    check("rst_mem_read", mem_bus.mem_read, 1);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_rf_we", rf_we, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 0);
    check("rst_mem_in", mem_bus.mem_in, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    tick();
    reset = 1'b0;
    tick();

    // start pulsed while busy must be ignored
    model_op(OP_SW, 6'h30, 3'd2, 8'h00);
    run_op(OP_SW, 6'h30, 3'd2, 8'h00, 2, lat);
    verify("ignore", lat);
    tick(); tick(); tick();
    check("ignore_no_extra_rd", rd_cnt - rd0, 0);
    check("ignore_no_extra_wr", wr_cnt - wr0, 1);
    check("ignore_idle", busy, 0);

    // Reset after the second LM word: first two registers updated only
    begin
      int k;
      rd0 = rd_cnt; wr0 = wr_cnt;
      rf_log.delete();
      op = OP_LM; base_addr = 6'h08; reg_mask = 8'h0F; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (rf_log.size() < 2 && k < 50) begin
        tick();
        k++;
      end
      check("abort_reached", rf_log.size(), 2);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_strobes", {mem_bus.mem_write, mem_bus.mem_read}, 2'b11);
      check("abort_rf_we", rf_we, 0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      exp_rf[0] = exp_mem[6'h08];
      exp_rf[1] = exp_mem[6'h09];
      check("abort_rf_writes", rf_log.size(), 2);
      check("abort_reads", rd_cnt - rd0, 2);
      check("abort_r0", rf[0], exp_rf[0]);
      check("abort_r1", rf[1], exp_rf[1]);
      check("abort_r2", rf[2], exp_rf[2]);
      check("abort_r3", rf[3], exp_rf[3]);
      check("abort_idle", busy, 0);
    end

    // Randomized operations against the reference
    for (int n = 0; n < 40; n++) begin
      logic [5:0] rb;
      logic [2:0] rs;
      logic [7:0] rm;
      ro = 2'($urandom_range(0, 3));
      rb = 6'($urandom);
      rs = 3'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model_op(ro, rb, rs, rm);
      run_op(ro, rb, rs, rm, 0, lat);
      verify($sformatf("rnd%0d", n), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
